// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between two requesters;
// partial stores use read-modify-write. Define DMEM_ARB_RANGE_CHECK_EN to add p0_err/p1_err.
module dmem_arbiter #(
    parameter int DEPTH = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_be,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_be,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_RANGE_CHECK_EN
    ,
    output logic        p0_err,
    output logic        p1_err
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic            r_port;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic [31:0]     r_merged;
    logic [31:0]     r_p0_rdata;
    logic [31:0]     r_p1_rdata;
    logic            r_p0_gnt;
    logic            r_p1_gnt;
    logic            r_p0_done;
    logic            r_p1_done;

    logic            w_grant;
    logic            w_gport;
    logic            w_sel_we;
    logic [31:0]     w_sel_addr;
    logic [31:0]     w_sel_wdata;
    logic [3:0]      w_sel_be;
    logic [31:0]     w_merged;
    logic            w_oob;
    logic            w_partial;
    logic            w_unused_bits;

    assign w_sel_we    = w_gport ? p1_we    : p0_we;
    assign w_sel_addr  = w_gport ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_gport ? p1_wdata : p0_wdata;
    assign w_sel_be    = w_gport ? p1_be    : p0_be;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);
    logic r_oob;
    logic r_p0_err;
    logic r_p1_err;
    assign w_oob  = r_oob;
    assign p0_err = r_p0_err;
    assign p1_err = r_p1_err;
`else
    assign w_oob = 1'b0;
`endif

    // Only partial masks need the old word; full and empty masks finish in ACCESS.
    assign w_partial     = r_we && !w_oob && (r_be != 4'hF) && (r_be != 4'h0);
    assign w_unused_bits = ^{w_sel_addr[1:0], w_sel_addr[31:AW+2]};

    always_comb begin
        w_merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_grant = 1'b0;
        w_gport = 1'b0;
        w_next  = r_state;
        case (r_state)
            S_IDLE: begin
                if (p0_req && p1_req) begin
                    w_grant = 1'b1;
                    w_gport = ~r_last;
                end else if (p0_req || p1_req) begin
                    w_grant = 1'b1;
                    w_gport = p1_req;
                end
                if (w_grant) w_next = S_ACCESS;
            end
            S_ACCESS: w_next = w_partial ? S_WRITE : S_IDLE;
            S_WRITE:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_wen   = 1'b0;
        mem_wdata = 32'h0;
        case (r_state)
            S_ACCESS: begin
                if (r_we && !w_oob && (r_be == 4'hF)) begin
                    mem_wen   = 1'b1;
                    mem_wdata = r_wdata;
                end
            end
            S_WRITE: begin
                mem_wen   = 1'b1;
                mem_wdata = r_merged;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_be       <= 4'h0;
            r_merged   <= 32'h0;
            r_p0_rdata <= 32'h0;
            r_p1_rdata <= 32'h0;
            r_p0_gnt   <= 1'b0;
            r_p1_gnt   <= 1'b0;
            r_p0_done  <= 1'b0;
            r_p1_done  <= 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
            r_oob      <= 1'b0;
            r_p0_err   <= 1'b0;
            r_p1_err   <= 1'b0;
`endif
        end else begin
            r_p0_gnt  <= 1'b0;
            r_p1_gnt  <= 1'b0;
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
            r_p0_err  <= 1'b0;
            r_p1_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_port   <= w_gport;
                        r_last   <= w_gport;
                        r_we     <= w_sel_we;
                        r_addr   <= w_sel_addr[AW+1:2];
                        r_wdata  <= w_sel_wdata;
                        r_be     <= w_sel_be;
                        r_p0_gnt <= ~w_gport;
                        r_p1_gnt <= w_gport;
`ifdef DMEM_ARB_RANGE_CHECK_EN
                        r_oob    <= (w_sel_addr >= BYTE_LIMIT);
`endif
                    end
                end
                S_ACCESS: begin
                    if (w_partial) begin
                        r_merged <= w_merged;
                    end else begin
                        r_p0_done <= ~r_port;
                        r_p1_done <= r_port;
                        if (!r_we && !w_oob) begin
                            if (r_port) r_p1_rdata <= mem_rdata;
                            else        r_p0_rdata <= mem_rdata;
                        end
`ifdef DMEM_ARB_RANGE_CHECK_EN
                        r_p0_err <= w_oob & ~r_port;
                        r_p1_err <= w_oob & r_port;
`endif
                    end
                end
                S_WRITE: begin
                    r_p0_done <= ~r_port;
                    r_p1_done <= r_port;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = {{(32-AW){1'b0}}, r_addr};
    assign p0_gnt   = r_p0_gnt;
    assign p1_gnt   = r_p1_gnt;
    assign p0_done  = r_p0_done;
    assign p1_done  = r_p1_done;
    assign p0_rdata = r_p0_rdata;
    assign p1_rdata = r_p1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected grants, responses
// and memory writes; a negedge monitor pops and compares them as the DUT produces them.
module tb_dmem_arbiter;
    localparam int DEPTH = 8192;
    localparam int AW    = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_done;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_be;
    logic        p1_req, p1_we, p1_gnt, p1_done;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    logic        p0_err, p1_err;
`endif

    logic [31:0] mem [DEPTH];

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_be(p0_be), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_be(p1_be), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_RANGE_CHECK_EN
        , .p0_err(p0_err), .p1_err(p1_err)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[AW-1:0]];
    always @(posedge clk) if (mem_wen) mem[mem_addr[AW-1:0]] <= mem_wdata;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        int          lat;
        logic        err;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t q_resp0[$];
    resp_t q_resp1[$];
    wr_t   q_wr[$];
    int    q_gnt[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    g_cyc0 = 0;
    int    g_cyc1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        total++;
        bad++;
        $display("FAIL %s: got an unexpected pulse, required none", name);
    endtask

    task automatic mon_done(input int p, input logic [31:0] rd, input int lat);
        resp_t e;
        if (p == 0 && q_resp0.size() == 0) unexp("p0_done");
        else if (p == 1 && q_resp1.size() == 0) unexp("p1_done");
        else begin
            if (p == 0) e = q_resp0.pop_front();
            else        e = q_resp1.pop_front();
            chk($sformatf("p%0d_done_latency", p), 32'(lat), 32'(e.lat));
            if (e.is_load) chk($sformatf("p%0d_rdata", p), rd, e.rdata);
`ifdef DMEM_ARB_RANGE_CHECK_EN
            chk($sformatf("p%0d_err", p), {31'b0, (p == 0) ? p0_err : p1_err}, {31'b0, e.err});
`endif
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (p0_gnt || p1_gnt) begin
                if (p0_gnt && p1_gnt) unexp("gnt_both_ports");
                if (q_gnt.size() == 0) unexp("gnt");
                else chk("gnt_port", {31'b0, p1_gnt}, 32'(q_gnt.pop_front()));
                if (p0_gnt) g_cyc0 = cyc;
                if (p1_gnt) g_cyc1 = cyc;
            end
            if (p0_done && p1_done) unexp("done_both_ports");
            if (p0_done) mon_done(0, p0_rdata, cyc - g_cyc0);
            if (p1_done) mon_done(1, p1_rdata, cyc - g_cyc1);
            if (mem_wen) begin
                if (q_wr.size() == 0) unexp("mem_wen");
                else begin
                    wr_t w;
                    w = q_wr.pop_front();
                    chk("mem_addr", mem_addr, w.addr);
                    chk("mem_wdata", mem_wdata, w.data);
                end
            end
        end
    end

    task automatic exp_resp(input int p, input logic ld, input logic [31:0] rd, input int lat,
                            input logic er);
        resp_t e;
        e.is_load = ld; e.rdata = rd; e.lat = lat; e.err = er;
        q_gnt.push_back(p);
        if (p == 0) q_resp0.push_back(e);
        else        q_resp1.push_back(e);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        q_wr.push_back(w);
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = wd; p0_be = be;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = wd; p1_be = be;
        end
    endtask

    task automatic wait_gnt(input int p);
        logic got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if ((p == 0 && p0_gnt) || (p == 1 && p1_gnt)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL gnt_timeout: port %0d got no grant, required one within 20 cycles", p);
        end
    endtask

    // Inputs are scrambled right after the grant to show the access uses latched values.
    task automatic issue(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        drive(p, 1'b1, we, a, wd, be);
        wait_gnt(p);
        drive(p, 1'b0, ~we, 32'hFFFF_FFFC, 32'hBAD0_BAD0, ~be);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic contend(input int ncyc, input logic [31:0] a0, input logic [31:0] a1);
        drive(0, 1'b1, 1'b0, a0, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, a1, 32'h0, 4'h0);
        repeat (ncyc) @(posedge clk);
        #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        mem[0] <= 32'hCAFE_F00D;
        mem[2] <= 32'hAABB_CCDD;
        mem[3] <= 32'h1234_5678;
        mem[4] <= 32'hDEAD_BEEF;
        mem[5] <= 32'h5566_7788;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p0_gnt", {31'b0, p0_gnt}, 32'h0);
        chk("rst_p1_done", {31'b0, p1_done}, 32'h0);
        chk("rst_mem_wen", {31'b0, mem_wen}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single-port load, full store, reload
        exp_resp(0, 1'b1, 32'hDEAD_BEEF, 1, 1'b0);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        exp_resp(1, 1'b0, 32'h0, 1, 1'b0);
        exp_wr(32'd8, 32'h1122_3344);
        issue(1, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF);
        chk("p0_rdata_held", p0_rdata, 32'hDEAD_BEEF);
        exp_resp(1, 1'b1, 32'h1122_3344, 1, 1'b0);
        issue(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);

        // partial stores and an empty-mask store
        exp_resp(0, 1'b0, 32'h0, 2, 1'b0);
        exp_wr(32'd2, 32'hAABB_CC55);
        issue(0, 1'b1, 32'h0000_0008, 32'h0000_0055, 4'b0001);
        chk("mem2_merged", mem[2], 32'hAABB_CC55);
        exp_resp(0, 1'b0, 32'h0, 1, 1'b0);
        issue(0, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0000);
        chk("mem1_untouched", mem[1], 32'h0);
        exp_resp(1, 1'b0, 32'h0, 2, 1'b0);
        exp_wr(32'd3, 32'hA034_C078);
        issue(1, 1'b1, 32'h0000_000C, 32'hA0B0_C0D0, 4'b1010);

        // contention after a port-1 access: p0, p1, p0, p1
        exp_resp(0, 1'b1, 32'hDEAD_BEEF, 1, 1'b0);
        exp_resp(1, 1'b1, 32'h1122_3344, 1, 1'b0);
        exp_resp(0, 1'b1, 32'hDEAD_BEEF, 1, 1'b0);
        exp_resp(1, 1'b1, 32'h1122_3344, 1, 1'b0);
        contend(8, 32'h0000_0010, 32'h0000_0020);

        // reset in the WRITE cycle of a partial store
        q_gnt.push_back(0);
        drive(0, 1'b1, 1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'b0011);
        wait_gnt(0);
        p0_req = 1'b0;
        @(posedge clk);
        #1;
        chk("write_cycle_wen", {31'b0, mem_wen}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_mem_wen", {31'b0, mem_wen}, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        chk("abort_p0_rdata", p0_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_mem5", mem[5], 32'h5566_7788);
        exp_resp(0, 1'b1, 32'hDEAD_BEEF, 1, 1'b0);
        exp_resp(1, 1'b1, 32'h1122_3344, 1, 1'b0);
        contend(4, 32'h0000_0010, 32'h0000_0020);

        // address beyond DEPTH words
`ifdef DMEM_ARB_RANGE_CHECK_EN
        exp_resp(1, 1'b1, 32'h1122_3344, 1, 1'b1);
`else
        exp_resp(1, 1'b1, 32'hCAFE_F00D, 1, 1'b0);
`endif
        issue(1, 1'b0, 32'h0000_8000, 32'h0, 4'h0);

        chk("resp0_drained", 32'(q_resp0.size()), 32'h0);
        chk("resp1_drained", 32'(q_resp1.size()), 32'h0);
        chk("wr_drained", 32'(q_wr.size()), 32'h0);
        chk("gnt_drained", 32'(q_gnt.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port word-addressed data memory between two requesters: port 0 (core load/store path) and port 1 (DMA/debug loader).
- Round-robin arbitration with a req/gnt/done handshake.
- Byte-enable stores are performed as read-modify-write, since the memory only supports whole-word writes.
- Sits between the requesters and data_mem; owns the memory's address, write-data and write-enable pins exclusively.

Parameters:
- DEPTH, 8192, memory depth in 32-bit words; local AW = $clog2(DEPTH) word-index bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- p0_req  input  1  port 0 request; held until p0_gnt
- p0_we  input  1  1 = store, 0 = load
- p0_addr  input  32  byte address; word index = p0_addr[AW+1:2]; bits [1:0] ignored
- p0_wdata  input  32  store data, byte lanes aligned to the word
- p0_be  input  4  store byte enables; ignored on loads
- p0_gnt  output  1  one-cycle pulse: request accepted, inputs latched
- p0_done  output  1  one-cycle pulse: access complete
- p0_rdata  output  32  load data, valid in the p0_done cycle and held until the next port-0 load completes
- p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_gnt, p1_done, p1_rdata  as port 0, for port 1
- mem_addr  output  32  word index to data memory, zero-extended from AW bits
- mem_wdata  output  32  write data to data memory
- mem_wen  output  1  write enable to data memory (memory writes on posedge clk)
- mem_rdata  input  32  combinational read data from data memory

Behaviour:
- Reset: async, active-high. Forces FSM to IDLE.
  - Clears all outputs and latched registers.
  - last_grant = 1, so port 0 wins the first contention.
  - Reset mid-access aborts the access: no mem_wen after reset asserts, no done pulse.
- FSM states: IDLE, ACCESS, WRITE.
- IDLE:
  - mem_wen = 0.
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_grant.
  - On grant: pulse pX_gnt; latch we, addr index, wdata and be into an internal request register; update last_grant; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS: mem_addr = latched index.
  - Load: capture mem_rdata into pX_rdata; pulse pX_done; go to IDLE.
  - Store with be == 4'hF: mem_wen = 1, mem_wdata = latched wdata; pulse pX_done; go to IDLE.
  - Store with be == 4'h0: no write; pulse pX_done; go to IDLE.
  - Store, other be: merged[8i+7:8i] = be[i] ? wdata byte : mem_rdata byte; register merged; go to WRITE.
- WRITE: mem_addr = latched index; mem_wen = 1; mem_wdata = merged; pulse pX_done; go to IDLE.
- Latency from gnt cycle to done cycle:
  - 1 cycle for loads and full/empty-mask stores.
  - 2 cycles for partial stores.
  - Minimum spacing between consecutive grants: 2 cycles (full access), 3 cycles (partial store).
- gnt and done are never asserted for both ports in the same cycle.
- The non-granted port's req may stay high; it is served next (no starvation).
- Requester inputs may change after gnt without affecting the in-flight access.
- mem_addr is held at its last value when idle; mem_wen is never high in IDLE.

Optional Feature:
- Macro DMEM_ARB_RANGE_CHECK_EN.
- Defined:
  - Adds outputs p0_err and p1_err (1 bit each).
  - In ACCESS, if latched byte address >= DEPTH*4: no mem_wen, pulse pX_done together with pX_err, rdata unchanged, return to IDLE.
- Undefined:
  - No err ports.
  - Address is truncated to bits [AW+1:2], so out-of-range addresses wrap modulo DEPTH.

Test Plan:
- Reset, then p0 load from 0x0000_0010 with mem[4] = 0xDEADBEEF -> p0_gnt next edge; p0_done one cycle later with p0_rdata = 0xDEADBEEF; mem_wen never high.
- p1 store 0x0000_0020, wdata 0x11223344, be 4'hF -> mem_wen high for exactly one cycle at mem_addr 8; subsequent load returns 0x11223344.
- mem[2] = 0xAABBCCDD; p0 store addr 0x8, wdata 0x00000055, be 4'b0001 -> WRITE-state mem_wen with mem_wdata 0xAABBCC55; done 2 cycles after gnt.
- p0_req and p1_req both held high for 8 cycles, full-word loads -> grants alternate p0, p1, p0, p1; first grant to p0.
- Assert rst during WRITE of a partial store -> outputs go 0 immediately; target word unchanged; no done pulse; next contention grants p0 first.
- With DMEM_ARB_RANGE_CHECK_EN and DEPTH = 8192: p1 load at 0x0000_8000 -> p1_done and p1_err pulse together; no memory write. Without the macro: same address reads mem[0].
